post_core: RTL and testbench

POST_CORE -- requirements
Module: post_core

---
 rtl/post_core.sv | 198 +++++++++++++++++++
 tb/tb_post_core.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/post_core.sv
`default_nettype none
// ============================================================================
// Module   : post_core
// Summary  : Post-Turing tape machine: 4-bit opcodes from a 256x4 code RAM
//            operating on a 256x1 tape RAM. Optional single-step mode is
//            enabled by defining POST_CORE_STEP_EN (adds input 'step').
// Revision : 1.0 - initial release
// ============================================================================
module post_core (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       prg_mode,
`ifdef POST_CORE_STEP_EN
    input  logic       step,
`endif
    output logic [7:0] code_add,
    input  logic [3:0] code_din,
    output logic [7:0] data_add,
    input  logic       data_din,
    output logic       data_dout,
    output logic       data_we,
    output logic       busy,
    output logic       halted,
    output logic       err,
    output logic [7:0] pc,
    output logic [7:0] head
);

    localparam logic [3:0] c_OP_NOP   = 4'h0;
    localparam logic [3:0] c_OP_MARK  = 4'h1;
    localparam logic [3:0] c_OP_ERASE = 4'h2;
    localparam logic [3:0] c_OP_LEFT  = 4'h3;
    localparam logic [3:0] c_OP_RIGHT = 4'h4;
    localparam logic [3:0] c_OP_JMP   = 4'h5;
    localparam logic [3:0] c_OP_JZ    = 4'h6;
    localparam logic [3:0] c_OP_JNZ   = 4'h7;
    localparam logic [3:0] c_OP_HALT  = 4'hF;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_WRITE    = 4'd3,
        S_FETCH_HI = 4'd4,
        S_LATCH_HI = 4'd5,
        S_FETCH_LO = 4'd6,
        S_LATCH_LO = 4'd7,
        S_STOP     = 4'd8
    } state_t;

    state_t     r_state;
    logic [3:0] r_op;
    logic       r_bit;
    logic [3:0] r_hi;

    logic       w_step_ok;
    logic [7:0] w_pc_inc;
    logic [7:0] w_head_dec;
    logic [7:0] w_head_inc;
    logic [7:0] w_target;
    logic       w_taken;

`ifdef POST_CORE_STEP_EN
    assign w_step_ok = step;
`else
    assign w_step_ok = 1'b1;
`endif

    assign w_pc_inc   = pc + 8'd1;
    assign w_head_dec = head - 8'd1;
    assign w_head_inc = head + 8'd1;
    // Low target nibble is consumed straight off the code bus in LATCH_LO.
    assign w_target   = {r_hi, code_din};
    assign w_taken    = (r_op == c_OP_JMP) ||
                        ((r_op == c_OP_JZ)  && !r_bit) ||
                        ((r_op == c_OP_JNZ) &&  r_bit);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_op      <= 4'h0;
            r_bit     <= 1'b0;
            r_hi      <= 4'h0;
            pc        <= 8'h00;
            head      <= 8'h00;
            code_add  <= 8'h00;
            data_add  <= 8'h00;
            data_dout <= 1'b0;
            data_we   <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            err       <= 1'b0;
        end else if (prg_mode) begin
            r_state  <= S_IDLE;
            code_add <= 8'h00;
            data_add <= 8'h00;
            data_we  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            data_we <= 1'b0;
            case (r_state)
                S_IDLE, S_STOP: begin
                    if (start) begin
                        pc       <= 8'h00;
                        head     <= 8'h00;
                        code_add <= 8'h00;
                        data_add <= 8'h00;
                        halted   <= 1'b0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_step_ok) begin
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_op  <= code_din;
                    r_bit <= data_din;
                    pc    <= w_pc_inc;
                    case (code_din)
                        c_OP_NOP: begin
                            code_add <= w_pc_inc;
                            r_state  <= S_FETCH;
                        end
                        c_OP_LEFT: begin
                            head     <= w_head_dec;
                            data_add <= w_head_dec;
                            code_add <= w_pc_inc;
                            r_state  <= S_FETCH;
                        end
                        c_OP_RIGHT: begin
                            head     <= w_head_inc;
                            data_add <= w_head_inc;
                            code_add <= w_pc_inc;
                            r_state  <= S_FETCH;
                        end
                        c_OP_MARK, c_OP_ERASE: begin
                            data_we   <= 1'b1;
                            data_dout <= (code_din == c_OP_MARK);
                            data_add  <= head;
                            r_state   <= S_WRITE;
                        end
                        c_OP_JMP, c_OP_JZ, c_OP_JNZ: begin
                            code_add <= w_pc_inc;
                            r_state  <= S_FETCH_HI;
                        end
                        c_OP_HALT: begin
                            halted  <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_STOP;
                        end
                        default: begin
                            err     <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_STOP;
                        end
                    endcase
                end
                S_WRITE: begin
                    code_add <= pc;
                    r_state  <= S_FETCH;
                end
                S_FETCH_HI: begin
                    r_state <= S_LATCH_HI;
                end
                S_LATCH_HI: begin
                    r_hi     <= code_din;
                    pc       <= w_pc_inc;
                    code_add <= w_pc_inc;
                    r_state  <= S_FETCH_LO;
                end
                S_FETCH_LO: begin
                    r_state <= S_LATCH_LO;
                end
                S_LATCH_LO: begin
                    if (w_taken) begin
                        pc       <= w_target;
                        code_add <= w_target;
                    end else begin
                        pc       <= w_pc_inc;
                        code_add <= w_pc_inc;
                    end
                    r_state <= S_FETCH;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_post_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_post_core
// Summary  : Scoreboard bench for post_core with an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_post_core;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic       prg_mode = 1'b0;
`ifdef POST_CORE_STEP_EN
    logic       step = 1'b1;
`endif
    logic [7:0] code_add;
    logic [3:0] code_din;
    logic [7:0] data_add;
    logic       data_din;
    logic       data_dout;
    logic       data_we;
    logic       busy;
    logic       halted;
    logic       err;
    logic [7:0] pc;
    logic [7:0] head;

    post_core dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .prg_mode  (prg_mode),
`ifdef POST_CORE_STEP_EN
        .step      (step),
`endif
        .code_add  (code_add),
        .code_din  (code_din),
        .data_add  (data_add),
        .data_din  (data_din),
        .data_dout (data_dout),
        .data_we   (data_we),
        .busy      (busy),
        .halted    (halted),
        .err       (err),
        .pc        (pc),
        .head      (head)
    );

    always #5 CLK = ~CLK;

    // Synchronous memories: read data one clock after the address.
    logic [3:0]   code_mem [256];
    logic [255:0] tape_mem;
    logic [255:0] tape_init;
    logic         tape_load = 1'b0;

    always @(posedge CLK) begin
        code_din <= code_mem[code_add];
        data_din <= tape_mem[data_add];
        if (tape_load)
            tape_mem <= tape_init;
        else if (data_we)
            tape_mem[data_add] <= data_dout;
    end

    typedef struct {
        bit           halted;
        bit           err;
        int           pc;
        int           head;
        int           lat;
        int           nwr;
        logic [255:0] tape;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    bit   mon_skip = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_tape(input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL tape: got %h expected %h", act, exp);
        end
    endtask

    // Interprets whole instructions; latency is summed from the per-class table.
    function automatic exp_t model(input logic [255:0] t0, output bit ok);
        exp_t       e;
        int         p = 0;
        int         h = 0;
        int         n = 0;
        logic [3:0] op;
        logic [3:0] hi;
        logic [3:0] lo;
        bit         tk;
        e.halted = 1'b0;
        e.err    = 1'b0;
        e.lat    = 0;
        e.nwr    = 0;
        e.tape   = t0;
        ok       = 1'b0;
        while (n < 300 && !ok) begin
            op = code_mem[p];
            p  = (p + 1) % 256;
            n++;
            case (op)
                4'h0: e.lat += 2;
                4'h1, 4'h2: begin
                    e.tape[h] = (op == 4'h1);
                    e.lat += 3;
                    e.nwr++;
                end
                4'h3: begin h = (h + 255) % 256; e.lat += 2; end
                4'h4: begin h = (h + 1) % 256;   e.lat += 2; end
                4'h5, 4'h6, 4'h7: begin
                    hi = code_mem[p];
                    p  = (p + 1) % 256;
                    lo = code_mem[p];
                    p  = (p + 1) % 256;
                    e.lat += 6;
                    tk = (op == 4'h5) || (op == 4'h6 && e.tape[h] == 1'b0) ||
                         (op == 4'h7 && e.tape[h] == 1'b1);
                    if (tk) p = int'({hi, lo});
                end
                4'hF: begin e.halted = 1'b1; e.lat += 2; ok = 1'b1; end
                default: begin e.err = 1'b1; e.lat += 2; ok = 1'b1; end
            endcase
        end
        e.pc   = p;
        e.head = h;
        return e;
    endfunction

    // Monitor: a run ends when busy falls; compare against the oldest expectation.
    int busy_cyc = 0;
    int we_cyc   = 0;
    int we_idle  = 0;
    bit prev_busy = 1'b0;

    always @(negedge CLK) begin
        if (busy && !prev_busy) begin
            busy_cyc = 0;
            we_cyc   = 0;
        end
        if (busy) busy_cyc++;
        if (data_we) begin
            if (busy) we_cyc++;
            else      we_idle++;
        end
        if (prev_busy && !busy && !mon_skip) begin
            if (sb.size() == 0) begin
                chk("unexpected_stop_queue", sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                chk("halted",  int'(halted), int'(mon_e.halted));
                chk("err",     int'(err),    int'(mon_e.err));
                chk("pc",      int'(pc),     mon_e.pc);
                chk("head",    int'(head),   mon_e.head);
                chk("latency", busy_cyc,     mon_e.lat);
                chk("writes",  we_cyc,       mon_e.nwr);
                chk("we_outside_run", we_idle, 0);
                chk_tape(tape_mem, mon_e.tape);
            end
        end
        prev_busy = busy;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Nibbles given high-first; remaining code filled with HALT.
    task automatic load_code(input int len, input logic [63:0] v);
        for (int i = 0; i < 256; i++)
            code_mem[i] = (i < len) ? v[4*(len-1-i) +: 4] : 4'hF;
    endtask

    task automatic run_prog(input logic [255:0] t, input bit poke);
        exp_t e;
        bit   ok;
        int   n;
        e = model(t, ok);
        tape_init = t;
        tape_load = 1'b1;
        tick(1);
        tape_load = 1'b0;
        sb.push_back(e);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        if (poke && e.lat > 8) begin
            tick(2);
            start = 1'b1;
            tick(1);
            start = 1'b0;
        end
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            tick(1);
            n++;
        end
        if (sb.size() != 0) begin
            chk("run_completed_queue", sb.size(), 0);
            sb.delete();
        end
        tick(2);
    endtask

    function automatic logic [3:0] rand_nib();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 88)      return 4'($urandom_range(0, 7));
        else if (r < 96) return 4'hF;
        else             return 4'($urandom_range(8, 14));
    endfunction

    logic [255:0] t;
    exp_t         tmp;
    bit           tok;
    int           pc_before;
    int           head_before;

    initial begin
        load_code(1, 64'hF);
        tape_init = '0;
        tape_mem  = '0;
        tick(3);
        RST = 1'b0;
        tick(1);
        chk("rst_busy",     int'(busy),      0);
        chk("rst_halted",   int'(halted),    0);
        chk("rst_err",      int'(err),       0);
        chk("rst_pc",       int'(pc),        0);
        chk("rst_head",     int'(head),      0);
        chk("rst_code_add", int'(code_add),  0);
        chk("rst_data_add", int'(data_add),  0);
        chk("rst_we",       int'(data_we),   0);
        chk("rst_dout",     int'(data_dout), 0);

        // Directed programs
        load_code(2, 64'h1F);
        run_prog('0, 1'b0);
        load_code(3, 64'h31F);
        run_prog('0, 1'b0);
        load_code(6, 64'h604F1F);
        run_prog('0, 1'b0);
        t = '0;
        t[0] = 1'b1;
        run_prog(t, 1'b0);
        load_code(1, 64'h9);
        run_prog('0, 1'b0);

        // Infinite loop, then programmer takeover and asynchronous reset
        load_code(3, 64'h500);
        mon_skip = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(20);
        pc_before   = int'(pc);
        head_before = int'(head);
        prg_mode = 1'b1;
        tick(1);
        chk("prg_busy",     int'(busy),     0);
        chk("prg_we",       int'(data_we),  0);
        chk("prg_code_add", int'(code_add), 0);
        chk("prg_data_add", int'(data_add), 0);
        chk("prg_pc_hold",  int'(pc),       pc_before);
        chk("prg_head_hold", int'(head),    head_before);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        chk("prg_start_ignored", int'(busy), 0);
        prg_mode = 1'b0;
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(13);
        #2 RST = 1'b1;
        #1;
        chk("arst_busy",     int'(busy),     0);
        chk("arst_pc",       int'(pc),       0);
        chk("arst_code_add", int'(code_add), 0);
        chk("arst_we",       int'(data_we),  0);
        tick(1);
        RST = 1'b0;
        tick(2);
        chk("post_rst_idle", int'(busy), 0);
        mon_skip = 1'b0;
        tick(1);

`ifdef POST_CORE_STEP_EN
        load_code(3, 64'h44F);
        mon_skip = 1'b1;
        step = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(10);
        chk("step_hold_head", int'(head), 0);
        chk("step_hold_busy", int'(busy), 1);
        for (int s = 1; s <= 2; s++) begin
            step = 1'b1;
            tick(1);
            step = 1'b0;
            tick(8);
            chk("step_head", int'(head), s);
        end
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(8);
        chk("step_halted", int'(halted), 1);
        chk("step_busy",   int'(busy),   0);
        step = 1'b1;
        mon_skip = 1'b0;
        tick(1);
`endif

        // Random programs on random tapes
        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < 8; k++)
                t[32*k +: 32] = $urandom;
            tok = 1'b0;
            for (int tries = 0; tries < 50 && !tok; tries++) begin
                for (int i = 0; i < 256; i++)
                    code_mem[i] = rand_nib();
                tmp = model(t, tok);
            end
            if (tok)
                run_prog(t, (r % 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
